// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pixel fetch path.
package sprite_pkg;

  localparam int unsigned SPR_W      = 32;
  localparam int unsigned SPR_H      = 32;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned TRANSP_IDX = 0;
  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned COMMIT_Y   = 480;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } sprite_pos_t;

  // Parked far outside the visible area so nothing is drawn before the first commit.
  localparam sprite_pos_t POS_HIDDEN = '{x: 10'h3FF, y: 10'h3FF};

endpackage

// File: rtl/sprite_pos_shadow.sv
// Double-buffered sprite position: writes land in a pending register and
// only reach the active register on the frame commit cycle.
module sprite_pos_shadow #(
  parameter int unsigned COMMIT_Y = sprite_pkg::COMMIT_Y
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  sprite_pkg::sprite_pos_t pos_next,
  input  logic                    pos_wr,
  output sprite_pkg::sprite_pos_t act
);
  import sprite_pkg::*;

  sprite_pos_t pend;
  logic        pend_valid;
  logic        commit;

  assign commit = (draw_x == '0) && (draw_y == 10'(COMMIT_Y));

  // Pending/active update; a write coinciding with commit bypasses pending so the newest value wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      act        <= POS_HIDDEN;
      pend       <= POS_HIDDEN;
      pend_valid <= 1'b0;
    end else if (commit) begin
      if (pos_wr) begin
        act        <= pos_next;
        pend       <= pos_next;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        act        <= pend;
        pend_valid <= 1'b0;
      end
    end else if (pos_wr) begin
      pend       <= pos_next;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite fetch: hit test, ROM address generation and a two-stage
// pipeline that aligns palette index, opacity and VGA sideband signals.
module sprite_pixel_fetch #(
  parameter int unsigned SPR_W    = sprite_pkg::SPR_W,
  parameter int unsigned SPR_H    = sprite_pkg::SPR_H,
  parameter int unsigned IDX_W    = sprite_pkg::IDX_W,
  parameter int unsigned ADDR_W   = sprite_pkg::ADDR_W,
  parameter int unsigned COMMIT_Y = sprite_pkg::COMMIT_Y
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [9:0]        pos_x_next,
  input  logic [9:0]        pos_y_next,
  input  logic              pos_wr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  index,
  output logic              opaque,
  output logic              blank_out,
  output logic              hs_out,
  output logic              vs_out
);
  import sprite_pkg::*;

  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);

  sprite_pos_t act;
  sprite_pos_t pos_next;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit;
  logic        hit_d1;
  logic        blank_d1;
  logic        hs_d1;
  logic        vs_d1;

  assign pos_next = '{x: pos_x_next, y: pos_y_next};

  sprite_pos_shadow #(
    .COMMIT_Y (COMMIT_Y)
  ) u_shadow (
    .clk      (vga_clk),
    .reset    (reset),
    .draw_x   (DrawX),
    .draw_y   (DrawY),
    .pos_next (pos_next),
    .pos_wr   (pos_wr),
    .act      (act)
  );

  // Stage 0: 11-bit differences; bit 10 set means the pixel lies left of / above the sprite.
  always_comb begin
    dx  = {1'b0, DrawX} - {1'b0, act.x};
    dy  = {1'b0, DrawY} - {1'b0, act.y};
    hit = !blank
          && !dx[10] && ({1'b0, dx[9:0]} < 11'(SPR_W))
          && !dy[10] && ({1'b0, dy[9:0]} < 11'(SPR_H));
  end

  // Stage 1: ROM address and delayed sideband.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      blank_d1 <= 1'b1;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
    end else begin
      rom_addr <= hit ? ADDR_W'({dy[YW-1:0], dx[XW-1:0]}) : '0;
      hit_d1   <= hit;
      blank_d1 <= blank;
      hs_d1    <= hs_in;
      vs_d1    <= vs_in;
    end
  end

  // Stage 2: palette index, opacity and aligned sideband.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      index     <= '0;
      opaque    <= 1'b0;
      blank_out <= 1'b1;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
    end else begin
      index     <= hit_d1 ? rom_q : '0;
      opaque    <= hit_d1 && (rom_q != IDX_W'(TRANSP_IDX));
      blank_out <= blank_d1;
      hs_out    <= hs_d1;
      vs_out    <= vs_d1;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch with a behavioural position model
// and a ROM that returns the low four address bits.
module tb_sprite_pixel_fetch;
  import sprite_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX   = '0;
  logic [9:0] DrawY   = '0;
  logic       blank   = 1'b1;
  logic       hs_in   = 1'b1;
  logic       vs_in   = 1'b1;
  logic [9:0] pos_x_next = '0;
  logic [9:0] pos_y_next = '0;
  logic       pos_wr  = 1'b0;
  logic [9:0] rom_addr;
  logic [3:0] rom_q;
  logic [3:0] index;
  logic       opaque, blank_out, hs_out, vs_out;

  always #5 vga_clk = ~vga_clk;

  assign rom_q = rom_addr[3:0];

  sprite_pixel_fetch #(
    .SPR_W (32), .SPR_H (32), .IDX_W (4), .ADDR_W (10), .COMMIT_Y (480)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .pos_x_next (pos_x_next),
    .pos_y_next (pos_y_next),
    .pos_wr     (pos_wr),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index      (index),
    .opaque     (opaque),
    .blank_out  (blank_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  typedef struct {
    logic [3:0] idx;
    logic       opq;
    logic       bl;
    logic       hs;
    logic       vs;
    logic [9:0] addr;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  string cur    = "init";

  int m_ax = 1023, m_ay = 1023, m_px = 1023, m_py = 1023;
  bit m_pv = 1'b0;

  task automatic step(input int x, input int y, input bit bl, input bit hs, input bit vs,
                      input bit wr, input int px, input int py, input bit rst);
    exp_t e;
    int   dx, dy, a;
    bit   hit, cm;
    @(negedge vga_clk);
    reset = rst; DrawX = 10'(x); DrawY = 10'(y); blank = bl; hs_in = hs; vs_in = vs;
    pos_wr = wr; pos_x_next = 10'(px); pos_y_next = 10'(py);
    if (rst) begin
      e = '{idx: 4'd0, opq: 1'b0, bl: 1'b1, hs: 1'b1, vs: 1'b1, addr: 10'd0};
      foreach (sbq[i]) sbq[i] = e;
      sbq.push_back(e);
      m_ax = 1023; m_ay = 1023; m_pv = 1'b0;
    end else begin
      dx  = x - m_ax;
      dy  = y - m_ay;
      hit = !bl && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
      a   = hit ? dy * 32 + dx : 0;
      e.addr = 10'(a);
      e.idx  = hit ? 4'(a % 16) : 4'd0;
      e.opq  = hit && (a % 16) != 0;
      e.bl = bl; e.hs = hs; e.vs = vs;
      sbq.push_back(e);
      cm = (x == 0) && (y == 480);
      if (cm && wr) begin
        m_ax = px; m_ay = py; m_pv = 1'b0;
      end else if (cm && m_pv) begin
        m_ax = m_px; m_ay = m_py; m_pv = 1'b0;
      end else if (wr) begin
        m_px = px; m_py = py; m_pv = 1'b1;
      end
    end
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, (x >= 640) || (y >= 480), 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Scoreboard: rom_addr belongs to the newest pixel, index/opaque/sideband to the one before it.
  always @(posedge vga_clk) begin
    exp_t e;
    #2;
    if (sbq.size() >= 1) begin
      checks++;
      if (rom_addr !== sbq[$].addr) begin
        errors++; $display("FAIL %s rom_addr got %0d want %0d", cur, rom_addr, sbq[$].addr);
      end
    end
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      checks++;
      if (index !== e.idx) begin
        errors++; $display("FAIL %s index got %0d want %0d", cur, index, e.idx);
      end
      checks++;
      if (opaque !== e.opq) begin
        errors++; $display("FAIL %s opaque got %0b want %0b", cur, opaque, e.opq);
      end
      checks++;
      if ({blank_out, hs_out, vs_out} !== {e.bl, e.hs, e.vs}) begin
        errors++; $display("FAIL %s sideband got %3b want %3b", cur, {blank_out, hs_out, vs_out}, {e.bl, e.hs, e.vs});
      end
    end
  end

  task automatic test_reset();
    cur = "reset";
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    #6;
    checks++;
    if ({index, opaque, blank_out, hs_out, vs_out} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_outputs got %h/%b%b%b%b want 0/0111", index, opaque, blank_out, hs_out, vs_out);
    end
    checks++;
    if ({dut.act.x, dut.act.y} !== {10'h3FF, 10'h3FF}) begin
      errors++; $display("FAIL reset_act got %0d,%0d want 1023,1023", dut.act.x, dut.act.y);
    end
    checks++;
    if (dut.u_shadow.pend_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pend_valid got %b want 0", dut.u_shadow.pend_valid);
    end
  endtask

  task automatic test_first_frame();
    cur = "first_frame";
    step(5, 5, 1'b0, 1'b1, 1'b1, 1'b1, 100, 50, 1'b0);
    #6;
    checks++;
    if (dut.u_shadow.pend_valid !== 1'b1 || dut.act.x !== 10'h3FF) begin
      errors++; $display("FAIL pending_write pend_valid %b act_x %0d want 1 1023", dut.u_shadow.pend_valid, dut.act.x);
    end
    for (int y = 48; y < 84; y++)
      for (int x = 96; x < 136; x++) pix(x, y);
    step(0, 480, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    #6;
    checks++;
    if ({dut.act.x, dut.act.y} !== {10'd100, 10'd50} || dut.u_shadow.pend_valid !== 1'b0) begin
      errors++; $display("FAIL commit act %0d,%0d pv %b want 100,50 0", dut.act.x, dut.act.y, dut.u_shadow.pend_valid);
    end
  endtask

  task automatic test_rom_index();
    cur = "rom_index";
    pix(100, 50);
    #6;
    checks++;
    if (rom_addr !== 10'd0) begin
      errors++; $display("FAIL origin_addr got %0d want 0", rom_addr);
    end
    pix(103, 52);
    #6;
    checks++;
    if (index !== 4'd0 || opaque !== 1'b0) begin
      errors++; $display("FAIL transparent_hit index %0d opaque %b want 0 0", index, opaque);
    end
    checks++;
    if (rom_addr !== 10'd67) begin
      errors++; $display("FAIL addr_103_52 got %0d want 67", rom_addr);
    end
    pix(104, 52);
    #6;
    checks++;
    if (index !== 4'd3 || opaque !== 1'b1) begin
      errors++; $display("FAIL index_103_52 index %0d opaque %b want 3 1", index, opaque);
    end
    for (int y = 50; y < 82; y++)
      for (int x = 100; x < 132; x++) pix(x, y);
  endtask

  task automatic test_edge_clip();
    int ys[10] = '{0, 1, 2, 469, 470, 471, 478, 479, 480, 481};
    cur = "edge_clip";
    step(10, 300, 1'b0, 1'b1, 1'b1, 1'b1, 630, 470, 1'b0);
    step(0, 480, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    foreach (ys[i]) begin
      for (int x = 0; x < 5; x++) pix(x, ys[i]);
      for (int x = 625; x < 646; x++) pix(x, ys[i]);
    end
    pix(0, 0);
    pix(639, 479);
    #6;
    checks++;
    if (opaque !== 1'b0) begin
      errors++; $display("FAIL no_wrap_0_0 opaque got %b want 0", opaque);
    end
    pix(640, 479);
    #6;
    checks++;
    if (index !== 4'd9 || opaque !== 1'b1) begin
      errors++; $display("FAIL corner_639_479 index %0d opaque %b want 9 1", index, opaque);
    end
    pix(0, 1);
    #6;
    checks++;
    if (opaque !== 1'b0 || blank_out !== 1'b1) begin
      errors++; $display("FAIL blanked_640 opaque %b blank_out %b want 0 1", opaque, blank_out);
    end
  endtask

  task automatic test_no_tearing();
    cur = "no_tearing";
    step(300, 100, 1'b0, 1'b1, 1'b1, 1'b1, 200, 200, 1'b0);
    for (int y = 470; y < 480; y++)
      for (int x = 630; x < 640; x++) pix(x, y);
    pix(200, 200);
    pix(201, 200);
    #6;
    checks++;
    if (opaque !== 1'b0 || dut.u_shadow.pend_valid !== 1'b1) begin
      errors++; $display("FAIL midframe_write opaque %b pv %b want 0 1", opaque, dut.u_shadow.pend_valid);
    end
    step(0, 480, 1'b1, 1'b1, 1'b1, 1'b1, 300, 10, 1'b0);
    #6;
    checks++;
    if ({dut.act.x, dut.act.y} !== {10'd300, 10'd10} || dut.u_shadow.pend_valid !== 1'b0) begin
      errors++; $display("FAIL collision act %0d,%0d pv %b want 300,10 0", dut.act.x, dut.act.y, dut.u_shadow.pend_valid);
    end
    for (int y = 8; y < 13; y++)
      for (int x = 298; x < 336; x++) pix(x, y);
  endtask

  task automatic test_sideband();
    bit bl_h[200], hs_h[200], vs_h[200];
    cur = "sideband";
    for (int i = 0; i < 200; i++) begin
      bl_h[i] = (i % 5) < 2;
      hs_h[i] = (i % 7) != 3;
      vs_h[i] = ((i / 16) % 2) == 1;
      step(300 + (i % 40), 10, bl_h[i], hs_h[i], vs_h[i], 1'b0, 0, 0, 1'b0);
      #6;
      if (i >= 1) begin
        checks++;
        if ({blank_out, hs_out, vs_out} !== {bl_h[i-1], hs_h[i-1], vs_h[i-1]}) begin
          errors++; $display("FAIL delay2_%0d got %3b want %3b", i - 1, {blank_out, hs_out, vs_out}, {bl_h[i-1], hs_h[i-1], vs_h[i-1]});
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    cur = "reset_midline";
    for (int x = 295; x < 341; x++) begin
      step(x, 12, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, x == 310);
      if (x == 310) begin
        #6;
        checks++;
        if ({index, opaque, blank_out, hs_out, vs_out} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
          errors++; $display("FAIL midline_reset got %h/%b%b%b%b want 0/0111", index, opaque, blank_out, hs_out, vs_out);
        end
        checks++;
        if ({dut.act.x, dut.act.y} !== {10'h3FF, 10'h3FF}) begin
          errors++; $display("FAIL midline_reset_act got %0d,%0d want 1023,1023", dut.act.x, dut.act.y);
        end
      end
    end
    step(0, 480, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    #6;
    checks++;
    if ({dut.act.x, dut.act.y} !== {10'h3FF, 10'h3FF}) begin
      errors++; $display("FAIL hidden_after_commit got %0d,%0d want 1023,1023", dut.act.x, dut.act.y);
    end
    for (int y = 8; y < 13; y++)
      for (int x = 298; x < 336; x++) pix(x, y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_rom_index();
    test_edge_clip();
    test_no_tearing();
    test_sideband();
    test_reset_midline();
    cur = "drain";
    repeat (3) pix(700, 500);
    @(negedge vga_clk);
    @(negedge vga_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Per-pixel sprite fetch stage that sits directly upstream of the sprite palette lookup. From the VGA controller's current pixel coordinates and a frame-synchronously committed sprite position, it generates the sprite ROM address, absorbs the ROM's one-cycle read latency, and emits a palette index plus an opacity flag. VGA sync and blank are delayed to stay aligned with the index. The palette stage maps the index to RGB; index 0 is the chroma key (magenta) and is always reported as transparent.

## Interface
Parameters:
- SPR_W, 32, sprite width in pixels; power of two.
- SPR_H, 32, sprite height in pixels; power of two.
- IDX_W, 4, palette index width.
- ADDR_W, 10, ROM address width; equals log2(SPR_W*SPR_H).
- COMMIT_Y, 480, DrawY line on which the pending position commits (first non-visible line).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  high outside the visible area.
- hs_in, vs_in  in  1 each  active-low syncs from the VGA controller.
- pos_x_next, pos_y_next  in  10 each  new sprite top-left corner.
- pos_wr  in  1  one-cycle strobe; captures pos_*_next into the pending registers.
- rom_addr  out  ADDR_W  registered sprite ROM address.
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr.
- index  out  IDX_W  palette index for the aligned pixel.
- opaque  out  1  high when the sprite covers the pixel and index != 0.
- blank_out, hs_out, vs_out  out  1 each  inputs delayed by 2 cycles.

## Operation
- Position shadowing: pos_wr loads pend_x/pend_y and sets pend_valid. The commit cycle is DrawX==0 && DrawY==COMMIT_Y.
  - On a commit cycle with pend_valid=1, act_x/act_y take pend_x/pend_y and pend_valid clears.
  - If pos_wr coincides with a commit, the new pos_*_next commits directly and pend_valid ends at 0 (the newest value wins).
  - A pos_wr mid-frame never alters the current frame's rendering (no tearing).
- Stage 0 (combinational on inputs):
  - dx = {1'b0,DrawX} - {1'b0,act_x} and dy = {1'b0,DrawY} - {1'b0,act_y}, computed 11-bit signed.
  - hit = !blank && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H.
  - Signed compare means no wrap-around: a sprite at act_x=630 shows columns 0-9 only, and nothing appears at the left edge.
- Stage 1 (registered):
  - rom_addr = hit ? {dy[log2 SPR_H-1:0], dx[log2 SPR_W-1:0]} : 0.
  - hit_d1, blank, hs_in and vs_in are registered alongside.
- Stage 2 (registered):
  - index = hit_d1 ? rom_q : 0.
  - opaque = hit_d1 && rom_q != 0.
  - The delay-1 sideband signals advance to blank_out, hs_out and vs_out.
- Reset values:
  - act_x = act_y = 10'h3FF, so the sprite is off-screen until the first commit.
  - pend_valid = 0; rom_addr = 0; index = 0; opaque = 0.
  - blank_out = 1, hs_out = 1, vs_out = 1, and all pipeline sideband registers take the same values.

## Timing
- Latency from DrawX/DrawY/blank/syncs to index/opaque/*_out is exactly 2 vga_clk cycles, fixed. Throughput is one pixel per cycle, with no stalls.
- rom_addr is registered one cycle after its inputs. The ROM must present rom_q in the next cycle (synchronous BRAM, no output register).
- A commit takes effect on the pixel sampled in the cycle after the commit cycle. Since COMMIT_Y is non-visible, the whole next frame uses the new position.
- Reset asserted mid-frame: on the next edge all registers take their reset values and the pipeline contents are discarded. After release, outputs are valid 2 cycles later. The sprite stays hidden until a pos_wr followed by a commit cycle.

## Structure
- Package sprite_pkg holds:
  - SPR_W, SPR_H, IDX_W, ADDR_W, TRANSP_IDX (=0), H_ACTIVE (640), V_ACTIVE (480), COMMIT_Y.
  - typedef sprite_pos_t (struct of two 10-bit fields).
- One natural sub-module is sprite_pos_shadow: it contains the pending and active registers, pend_valid, and the commit detect with the collision rule. The pixel pipeline stays in the top.
- The sprite ROM is external, so the block can share ROM or palette wiring with other sprites.

## Test plan
- Reset, then pos_wr with (100,50), then run to the commit line: rows 0-479 of the first frame show opaque=0 everywhere. In the next frame, DrawX=100, DrawY=50 gives rom_addr=0 one cycle later and index=rom_q two cycles later.
- ROM model returning addr[3:0]: at DrawX=103, DrawY=52 with pos (100,50), rom_addr=67 and index=3. A pixel at index 0 gives opaque=0 while the sprite covers it.
- Edge clip: pos (630,470) shows hits only for DrawX 630-639, DrawY 470-479. Pixels at DrawX 0 and DrawY 0 give opaque=0, and blanked pixels at DrawX 640+ give opaque=0.
- pos_wr (200,200) at DrawY=100 mid-frame: the rest of the frame still renders at the old position. pos_wr issued exactly on the commit cycle with (300,10) commits (300,10) and leaves pend_valid=0.
- Sideband alignment: toggle hs_in, vs_in and blank with distinct patterns and check each *_out equals its input delayed by exactly 2 cycles.
- Assert reset for one cycle mid-line while the sprite is visible: the next cycle shows index=0, opaque=0, blank_out=1, hs_out=1, vs_out=1 and act=(1023,1023). The sprite stays hidden in later frames with no new pos_wr.
